wb_uart_tx_console: RTL and testbench

Transmit-only 16550-subset UART. It is a Wishbone slave on the SoC's UART target port and consumes the 24-bit UART bus the interconnect exports. Bytes written by the OR10 test suite go into a TX FIFO and are serialised as 8N1 on `uart_tx_o`. `uart_int_o` feeds the interrupt input that drives PIC line 2.

---
 rtl/wb_uart_tx_console.sv | 214 +++++++++++++++++++++
 tb/tb_wb_uart_tx_console.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx_console.sv
// Transmit-only 16550-subset UART behind a Wishbone slave port.
// Bytes written to THR are queued in a FIFO and sent as 8N1 on uart_tx_o.
module wb_uart_tx_console #(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [23:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        uart_int_o,
    output logic        uart_tx_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               ier_etbei;
    logic               lsr_oe;
    tx_state_t          state;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;

    logic        bus_req;
    logic        legal;
    logic        acc;
    logic [2:0]  reg_off;
    logic [3:0]  lane_sel;
    logic [7:0]  wr_byte;
    logic [7:0]  rd_byte;
    logic [31:0] rd_word;
    logic        fifo_empty;
    logic        fifo_full;
    logic        baud_end;
    logic        pop;
    logic        thr_write;
    logic        push_ok;
    logic        overflow;
    logic        ier_write;
    logic        lsr_read;
    logic        temt;

    // Decode: a request is only legal when the select matches the addressed byte lane.
    assign bus_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign reg_off   = wb_adr_i[2:0];
    assign lane_sel  = 4'b1000 >> wb_adr_i[1:0];
    assign legal     = (wb_adr_i[23:3] == 21'd0) && (wb_sel_i == lane_sel);
    assign acc       = bus_req & legal;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign temt       = fifo_empty && (state == ST_IDLE);

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands then.
    assign pop       = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));
    assign thr_write = acc & wb_we_i & (reg_off == 3'd0);
    assign push_ok   = thr_write & (!fifo_full | pop);
    assign overflow  = thr_write & fifo_full & !pop;
    assign ier_write = acc & wb_we_i & (reg_off == 3'd1);
    assign lsr_read  = acc & !wb_we_i & (reg_off == 3'd5);

    always_comb begin
        wr_byte = 8'h00;
        case (wb_adr_i[1:0])
            2'd0: wr_byte = wb_dat_i[31:24];
            2'd1: wr_byte = wb_dat_i[23:16];
            2'd2: wr_byte = wb_dat_i[15:8];
            2'd3: wr_byte = wb_dat_i[7:0];
            default: wr_byte = 8'h00;
        endcase
    end

    always_comb begin
        rd_byte = 8'h00;
        case (reg_off)
            3'd1: rd_byte = {6'b0, ier_etbei, 1'b0};
            3'd5: rd_byte = {1'b0, temt, fifo_empty, 3'b0, lsr_oe, 1'b0};
            default: rd_byte = 8'h00;
        endcase
    end

    assign rd_word = {rd_byte, 24'h0} >> {wb_adr_i[1:0], 3'b000};

    // One wait state: ack/err rise for exactly one cycle, and read data is only non-zero then.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= bus_req & legal;
            wb_err_o <= bus_req & !legal;
            wb_dat_o <= (acc & !wb_we_i) ? rd_word : 32'h0;
        end
    end

    // An overflow on the same edge as an LSR read wins, so OE is never lost.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ier_etbei <= 1'b0;
            lsr_oe    <= 1'b0;
        end else begin
            if (ier_write)
                ier_etbei <= wr_byte[1];
            if (overflow)
                lsr_oe <= 1'b1;
            else if (lsr_read)
                lsr_oe <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= wr_byte;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            uart_tx_o  <= 1'b1;
            uart_int_o <= 1'b0;
        end else begin
            uart_int_o <= ier_etbei & fifo_empty;
            case (state)
                ST_IDLE: begin
                    uart_tx_o <= 1'b1;
                    baud_cnt  <= '0;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr];
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    uart_tx_o <= 1'b0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    uart_tx_o <= shift_reg[0];
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'd7)
                            state <= ST_STOP;
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    uart_tx_o <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= fifo_mem[rd_ptr];
                            state     <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx_console.sv
// Directed bench for wb_uart_tx_console: bus handshake, register map, FIFO overflow,
// interrupt timing and serial framing checked against a small line receiver.
module tb_wb_uart_tx_console;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;
    logic        irq;
    logic        tx;

    int total_checks = 0;
    int bad_checks = 0;
    int edge_cnt = 0;

    logic [8:0] rx_q[$];
    int         start_q[$];

    wb_uart_tx_console #(.CLK_DIV(DIV), .FIFO_AW(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_dat_o   (dat_r),
        .wb_sel_i   (sel),
        .wb_we_i    (we),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .uart_int_o (irq),
        .uart_tx_o  (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_edge(input int t);
        while (edge_cnt < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; returns at 1ns after the edge where ack/err is first seen.
    task automatic applyStimulus(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input logic w, output logic [31:0] rd, output logic got_ack,
                                 output logic got_err, output int at_edge);
        int n;
        @(negedge clk);
        adr = a; dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(ack || err) && n < 8);
        if (!(ack || err))
            checkOutput("bus_timeout", 32'd0, 32'd1);
        rd = dat_r; got_ack = ack; got_err = err; at_edge = edge_cnt;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 24'h0; dat_w = 32'h0;
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s, output int at_edge);
        logic [31:0] rd;
        logic        a_k;
        logic        e_k;
        applyStimulus(a, d, s, 1'b1, rd, a_k, e_k, at_edge);
        checkOutput("wr_ack_err", {30'b0, a_k, e_k}, 32'h2);
    endtask

    task automatic bus_read(input logic [23:0] a, input logic [3:0] s, output logic [31:0] rd, output int at_edge);
        logic a_k;
        logic e_k;
        applyStimulus(a, 32'h0, s, 1'b0, rd, a_k, e_k, at_edge);
        checkOutput("rd_ack_err", {30'b0, a_k, e_k}, 32'h2);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] b);
        logic [8:0] got;
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h000;
        checkOutput(tag, {23'b0, got}, {23'b0, 1'b1, b});
    endtask

    // Line receiver: samples each bit mid-way and records {stop, data} plus the start edge.
    logic [7:0] mon_byte;
    int         mon_start;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                mon_start = edge_cnt;
                repeat (DIV + DIV / 2) @(negedge clk);
                mon_byte[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    mon_byte[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                rx_q.push_back({tx, mon_byte});
                start_q.push_back(mon_start);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic        a_k;
        logic        e_k;
        logic [9:0]  fb;
        int          e;
        int          e0;
        int          m;
        int          gap;

        rst_n = 1'b0; adr = 24'h0; dat_w = 32'h0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx", {31'b0, tx}, 32'd1);
        checkOutput("rst_ack", {31'b0, ack}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_int", {31'b0, irq}, 32'd0);
        checkOutput("rst_dat", dat_r, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Abort a frame with reset while the start bit is on the line
        bus_write(24'h0, 32'h55000000, 4'b1000, e);
        wait_edge(e + 3);
        checkOutput("pre_abort_tx", {31'b0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1 checkOutput("abort_tx", {31'b0, tx}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("post_rst_tx", {31'b0, tx}, 32'd1);
        bus_read(24'h5, 4'b0100, rd, e);
        checkOutput("rst_lsr", rd, 32'h00600000);
        bus_read(24'h1, 4'b0100, rd, e);
        checkOutput("rst_ier", rd, 32'h0);
        bus_read(24'h0, 4'b1000, rd, e);
        checkOutput("thr_read", rd, 32'h0);
        repeat (50) @(posedge clk);
        #1;
        rx_q.delete();
        start_q.delete();

        // Single frame of 0x41
        bus_write(24'h0, 32'h41000000, 4'b1000, e);
        @(posedge clk);
        #1 checkOutput("lat_idle_tx", {31'b0, tx}, 32'd1);
        bus_read(24'h5, 4'b0100, rd, m);
        checkOutput("lat_edge", m, e + 2);
        checkOutput("lsr_busy", rd, 32'h00200000);
        fb = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 10 * DIV; k++) begin
            checkOutput("frame_bit", {31'b0, tx}, {31'b0, fb[k / DIV]});
            @(posedge clk);
            #1;
        end
        checkOutput("frame_end_tx", {31'b0, tx}, 32'd1);
        bus_read(24'h5, 4'b0100, rd, m);
        checkOutput("lsr_temt", rd, 32'h00600000);
        check_rx("rx_41", 8'h41);

        // Interrupt and back-to-back frames
        start_q.delete();
        bus_write(24'h1, 32'h00020000, 4'b0100, e);
        bus_read(24'h1, 4'b0100, rd, e);
        checkOutput("ier_rd", rd, 32'h00020000);
        repeat (2) @(posedge clk);
        #1 checkOutput("int_idle", {31'b0, irq}, 32'd1);
        bus_write(24'h0, 32'hA5000000, 4'b1000, m);
        checkOutput("int_pre_push", {31'b0, irq}, 32'd1);
        @(posedge clk);
        #1 checkOutput("int_drop", {31'b0, irq}, 32'd0);
        bus_write(24'h0, 32'h3C000000, 4'b1000, e);
        checkOutput("pace", e, m + 2);
        wait_edge(m + 41);
        checkOutput("int_busy", {31'b0, irq}, 32'd0);
        checkOutput("b2b_stop", {31'b0, tx}, 32'd1);
        wait_edge(m + 42);
        checkOutput("int_rise", {31'b0, irq}, 32'd1);
        checkOutput("b2b_start", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 200 && rx_q.size() < 2; i++) @(posedge clk);
        #1;
        gap = (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1;
        checkOutput("b2b_gap", gap, 10 * DIV);
        checkOutput("first_start", (start_q.size() > 0) ? start_q[0] : -1, m + 2);
        check_rx("rx_a5", 8'hA5);
        check_rx("rx_3c", 8'h3C);

        // Illegal accesses terminate with err and change nothing
        applyStimulus(24'h000008, 32'h77000000, 4'b1000, 1'b1, rd, a_k, e_k, e);
        checkOutput("err_adr", {30'b0, a_k, e_k}, 32'h1);
        @(posedge clk);
        #1 checkOutput("err_one_cycle", {31'b0, err}, 32'd0);
        applyStimulus(24'h0, 32'h77770000, 4'b1100, 1'b1, rd, a_k, e_k, e);
        checkOutput("err_sel2", {30'b0, a_k, e_k}, 32'h1);
        applyStimulus(24'h1, 32'h00000000, 4'b1000, 1'b1, rd, a_k, e_k, e);
        checkOutput("err_lane", {30'b0, a_k, e_k}, 32'h1);
        bus_read(24'h1, 4'b0100, rd, e);
        checkOutput("ier_kept", rd, 32'h00020000);
        bus_write(24'h5, 32'h00FF0000, 4'b0100, e);
        repeat (12 * DIV) @(posedge clk);
        #1 checkOutput("no_tx_after_err", rx_q.size(), 32'd0);
        bus_read(24'h5, 4'b0100, rd, e);
        checkOutput("lsr_after_err", rd, 32'h00600000);
        bus_write(24'h1, 32'h00000000, 4'b0100, e);
        repeat (2) @(posedge clk);
        #1 checkOutput("int_off", {31'b0, irq}, 32'd0);

        // Overflow: one byte goes to the serialiser, 16 fill the FIFO, the 18th is dropped
        e0 = 0;
        for (int i = 0; i < 18; i++) begin
            bus_write(24'h0, {8'(8'h10 + i), 24'h0}, 4'b1000, e);
            if (i == 0) e0 = e;
        end
        checkOutput("burst_pace", e, e0 + 34);
        bus_read(24'h5, 4'b0100, rd, e);
        checkOutput("oe_set", rd, 32'h00020000);
        bus_read(24'h5, 4'b0100, rd, e);
        checkOutput("oe_clr", rd, 32'h0);
        wait_edge(e0 + 10 * DIV);
        bus_write(24'h0, 32'h30000000, 4'b1000, e);
        checkOutput("full_pop_edge", e, e0 + 10 * DIV + 1);
        bus_read(24'h5, 4'b0100, rd, e);
        checkOutput("oe_kept_clear", rd, 32'h0);
        bus_write(24'h0, 32'h31000000, 4'b1000, e);
        bus_read(24'h5, 4'b0100, rd, e);
        checkOutput("still_full", rd, 32'h00020000);
        for (int i = 0; i < 1200 && rx_q.size() < 18; i++) @(posedge clk);
        repeat (2 * DIV) @(posedge clk);
        #1 checkOutput("ovf_rx_count", rx_q.size(), 32'd18);
        for (int i = 0; i < 17; i++)
            check_rx("rx_ovf", 8'(8'h10 + i));
        check_rx("rx_full_push", 8'h30);
        bus_read(24'h5, 4'b0100, rd, e);
        checkOutput("final_lsr", rd, 32'h00600000);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
